uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
// - Parametrised UART transmitter: DBIT data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
// - Sits between a byte source (FIFO/CPU reg) and the serial pin; paced by the shared oversampling s_tick.
// - Replaces the fixed 8N1 transmitter; adds valid/ready handshake and runtime frame config.
// PARAMETERS
// - DBIT   8   data bits per frame, legal 5..9
// - OVS    16  s_ticks per bit period, legal 8..32
// PORTS
// - clk         in   1     system clock; all state updates on rising edge
// - reset       in   1     asynchronous, active-low reset
// - s_tick      in   1     one-clk oversampling strobe, OVS strobes per bit
// - tx_valid    in   1     source holds a word on din
// - tx_ready    out  1     block can accept a word (IDLE state)
// - din         in   DBIT  data word, sampled on accept
// - cfg_parity  in   2     00 none, 01 even, 10 odd, 11 none; sampled on accept
// - cfg_stop2   in   1     0 one stop bit, 1 two stop bits; sampled on accept
// - tx          out  1     serial line, idle high, registered
// - busy        out  1     frame in progress (state != IDLE)
// - tx_done_tick out 1     one-clk pulse at end of last stop bit
// BEHAVIOUR
// - Reset (reset==0): state IDLE, tx=1, tx_ready=1, busy=0, tx_done_tick=0, counters 0; takes effect immediately, also mid-frame.
// - Accept: tx_valid & tx_ready on a clk edge; latch din, cfg_parity, cfg_stop2; parity bit computed from latched data.
// - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
// - tx: 1 in IDLE/STOP, 0 in START, shift_reg[0] in DATA, parity bit in PARITY; registered, so tx=0 appears one clk after accept.
// - Tick counter s_cnt (5 b): increments only on s_tick; a bit ends on s_tick with s_cnt==OVS-1, then s_cnt<=0.
// - s_tick coincident with the accept cycle is not counted; START begins with s_cnt=0.
// - DATA: at each bit end shift right, n_cnt+1; after bit DBIT-1 go to PARITY if parity enabled, else STOP.
// - Parity bit: even = ^data, odd = ~^data, over DBIT latched bits only.
// - STOP lasts OVS (cfg_stop2=0) or 2*OVS (cfg_stop2=1) ticks; on final tick: tx_done_tick=1 for that clk, state->IDLE.
// - Frame length = OVS*(1+DBIT+P+S) s_ticks, P in {0,1}, S in {1,2}.
// - tx_ready = (state==IDLE); new accept allowed the clk after tx_done_tick -> zero idle-bit gap back-to-back.
// - tx_valid while busy: ignored, no side effect; source must hold din until accept.
// - Config/din changes mid-frame: no effect on the current frame.
// - No s_tick: all state frozen except handshake in IDLE.
// STRUCTURE
// - uart_pkg: state encodings (IDLE/START/DATA/PARITY/STOP), parity mode constants PAR_NONE/EVEN/ODD.
// - Single FSMD, no internal sub-module; s_tick comes from shared uart_baud_gen (also feeds receiver).
// - Registers: state, s_cnt, n_cnt, shift_reg[DBIT], par_bit, par_en, stop2, tx_reg.
// TESTING (DBIT=8, OVS=16, s_tick every 4 clk unless stated)
// - 8N1 din=8'hA5: tx bits 0,1,0,1,0,0,1,0,1,1 each 16 ticks; tx_done_tick after 160 ticks; tx_ready high next clk.
// - Even parity din=8'h07: parity bit 1; odd parity same data: parity bit 0; frame 176 ticks.
// - cfg_stop2=1, no parity, din=8'h00: tx high 32 ticks after data, done after 176 ticks.
// - tx_valid pulses with din=8'hFF during busy: ignored, tx_ready=0, frame in flight unchanged.
// - reset=0 mid-DATA (bit 3): tx=1 without clk, tx_ready=1, busy=0; next accept sends full frame.
// - tx_valid held high, din 8'h55 then 8'hAA: second start bit begins 1 clk after first tx_done_tick; DBIT=9 run repeats case 1 with 9'h1A5.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared state encodings and parity-mode constants for the
//               configurable UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Encoding 2'b11 is treated as "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : UART transmitter with DBIT data bits (LSB first), optional
//               even/odd parity and 1 or 2 stop bits, paced by s_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OVS  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic [DBIT-1:0] din,
    input  logic [1:0]      cfg_parity,
    input  logic            cfg_stop2,
    output logic            tx,
    output logic            busy,
    output logic            tx_done_tick
);

    localparam logic [4:0] C_S_LAST = 5'(OVS - 1);
    localparam logic [3:0] C_N_LAST = 4'(DBIT - 1);

    tx_state_t        r_state,   w_state_next;
    logic [4:0]       r_s_cnt,   w_s_cnt_next;
    logic [3:0]       r_n_cnt,   w_n_cnt_next;
    logic [DBIT-1:0]  r_shift,   w_shift_next;
    logic             r_par_bit, w_par_bit_next;
    logic             r_par_en,  w_par_en_next;
    logic             r_stop2,   w_stop2_next;
    logic             r_tx,      w_tx_next;
    logic             w_bit_end;
    logic             w_done;

    assign w_bit_end = s_tick && (r_s_cnt == C_S_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_s_cnt_next   = r_s_cnt;
        w_n_cnt_next   = r_n_cnt;
        w_shift_next   = r_shift;
        w_par_bit_next = r_par_bit;
        w_par_en_next  = r_par_en;
        w_stop2_next   = r_stop2;
        w_done         = 1'b0;

        // The oversampling counter only runs inside a frame, so a tick that
        // coincides with the accept cycle is never counted.
        if ((r_state != ST_IDLE) && s_tick)
            w_s_cnt_next = w_bit_end ? 5'd0 : r_s_cnt + 5'd1;

        case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_state_next   = ST_START;
                    w_s_cnt_next   = 5'd0;
                    w_n_cnt_next   = 4'd0;
                    w_shift_next   = din;
                    w_par_bit_next = (cfg_parity == PAR_ODD) ? ~^din : ^din;
                    w_par_en_next  = parity_enabled(cfg_parity);
                    w_stop2_next   = cfg_stop2;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                    w_n_cnt_next = 4'd0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_n_cnt == C_N_LAST) begin
                        w_n_cnt_next = 4'd0;
                        w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_n_cnt_next = r_n_cnt + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                    w_n_cnt_next = 4'd0;
                end
            end
            ST_STOP: begin
                // n_cnt counts completed stop bits so s_cnt can stay 5 bits wide.
                if (w_bit_end) begin
                    if (r_stop2 && (r_n_cnt == 4'd0)) begin
                        w_n_cnt_next = 4'd1;
                    end else begin
                        w_n_cnt_next = 4'd0;
                        w_done       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = w_par_bit_next;
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_s_cnt   <= 5'd0;
            r_n_cnt   <= 4'd0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_par_en  <= 1'b0;
            r_stop2   <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_s_cnt   <= w_s_cnt_next;
            r_n_cnt   <= w_n_cnt_next;
            r_shift   <= w_shift_next;
            r_par_bit <= w_par_bit_next;
            r_par_en  <= w_par_en_next;
            r_stop2   <= w_stop2_next;
            r_tx      <= w_tx_next;
        end
    end

    assign tx           = r_tx;
    assign tx_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign tx_done_tick = w_done;

endmodule
`default_nettype wire
